alu_share_arbiter: RTL and testbench

Shares one combinational RV32I ALU between `NREQ` requesters, e.g. the integer pipeline, an address-generation helper, and a debug or CSR path. It accepts one operation per requester through a valid/ready request channel and grants the ALU by round-robin. It registers the operands, drives the ALU, captures the result and returns it on the winning requester's valid/ready response channel. The ALU instance sits outside this block; the arbiter drives its operand and control inputs and samples its result.

---
 rtl/alu_pkg.sv | 39 +++
 rtl/alu_share_arbiter_rr_picker.sv | 36 +++
 rtl/alu_share_arbiter.sv | 130 +++++++++++++
 tb/tb_alu_share_arbiter.sv | 357 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Purpose: shared types and helpers for the shared-ALU arbiter (op codes, FSM states).
// Latency: n/a (declarations only).
// Backpressure: n/a.
package alu_pkg;

    // ALU control codes understood by the external RV32I ALU
    typedef enum logic [3:0] {
        ALU_ADD    = 4'd0,
        ALU_SUB    = 4'd1,
        ALU_SLL    = 4'd2,
        ALU_SLT    = 4'd3,
        ALU_XOR    = 4'd4,
        ALU_SLTU   = 4'd5,
        ALU_SRL    = 4'd6,
        ALU_SRA    = 4'd7,
        ALU_OR     = 4'd8,
        ALU_AND    = 4'd9,
        ALU_PASS_B = 4'd10
    } alu_op_e;

    localparam logic [3:0] ALU_OP_LAST = 4'd10;

    // Raw state encodings kept as plain constants so older code can compare against them
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_EXEC = 2'd1;
    localparam logic [1:0] ST_RESP = 2'd2;

    typedef enum logic [1:0] {
        ARB_IDLE = ST_IDLE,
        ARB_EXEC = ST_EXEC,
        ARB_RESP = ST_RESP
    } arb_state_e;

    // Codes above ALU_OP_LAST have no ALU meaning and are reported as errors
    function automatic logic is_legal_op(input logic [3:0] op);
        return (op <= ALU_OP_LAST);
    endfunction

endpackage

// File: rtl/alu_share_arbiter_rr_picker.sv
// Purpose: round-robin picker; first asserted request at or after ptr, wrapping at NREQ-1.
// Latency: purely combinational.
// Backpressure: none; caller decides whether the grant is used.
module rr_picker #(
    parameter int NREQ = 2,
    parameter int IW   = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [IW-1:0]   ptr,
    output logic [NREQ-1:0] gnt,
    output logic [IW-1:0]   gnt_idx
);

    logic          w_found;
    logic [IW:0]   w_sum;
    logic [IW-1:0] w_cand;

    // Walk candidates ptr, ptr+1, ... with explicit wrap so non-power-of-two NREQ works
    always_comb begin
        gnt     = '0;
        gnt_idx = '0;
        w_found = 1'b0;
        w_sum   = '0;
        w_cand  = '0;
        for (int k = 0; k < NREQ; k++) begin
            w_sum  = {1'b0, ptr} + (IW+1)'(k);
            w_cand = (w_sum >= (IW+1)'(NREQ)) ? IW'(w_sum - (IW+1)'(NREQ)) : IW'(w_sum);
            if (!w_found && req[w_cand]) begin
                w_found       = 1'b1;
                gnt[w_cand]   = 1'b1;
                gnt_idx       = w_cand;
            end
        end
    end

endmodule

// File: rtl/alu_share_arbiter.sv
// Purpose: time-shares one external combinational ALU between NREQ requesters, round-robin.
// Latency: accept edge T, result captured at T+1, rsp_valid held from T+1 until rsp_ready.
// Backpressure: no new grant while a result is outstanding; RESP holds until owner's rsp_ready.
module alu_share_arbiter
    import alu_pkg::*;
#(
    parameter int NREQ = 2,
    parameter int XLEN = 32
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [NREQ-1:0]           req_valid,
    output logic [NREQ-1:0]           req_ready,
    input  logic [NREQ-1:0][XLEN-1:0] req_a,
    input  logic [NREQ-1:0][XLEN-1:0] req_b,
    input  logic [NREQ-1:0][3:0]      req_op,
    output logic [NREQ-1:0]           rsp_valid,
    input  logic [NREQ-1:0]           rsp_ready,
    output logic [XLEN-1:0]           rsp_data,
    output logic                      rsp_err,
    output logic [XLEN-1:0]           alu_a,
    output logic [XLEN-1:0]           alu_b,
    output logic [3:0]                alu_ctrl,
    input  logic [XLEN-1:0]           alu_result,
    output logic                      busy
);

    localparam int IW = $clog2(NREQ);

    arb_state_e      r_state;
    logic [IW-1:0]   r_ptr;
    logic [IW-1:0]   r_gnt;
    logic            r_err;
    logic [XLEN-1:0] r_alu_a;
    logic [XLEN-1:0] r_alu_b;
    logic [3:0]      r_alu_ctrl;
    logic [XLEN-1:0] r_rsp_data;
    logic            r_rsp_err;

    logic [NREQ-1:0] w_gnt;
    logic [IW-1:0]   w_gnt_idx;
    logic            w_accept;
    logic [3:0]      w_op;
    logic [NREQ-1:0] w_rsp_onehot;

    rr_picker #(
        .NREQ (NREQ),
        .IW   (IW)
    ) u_picker (
        .req     (req_valid),
        .ptr     (r_ptr),
        .gnt     (w_gnt),
        .gnt_idx (w_gnt_idx)
    );

    assign w_accept  = (r_state == ARB_IDLE) && (|req_valid);
    assign w_op      = req_op[w_gnt_idx];
    assign req_ready = (r_state == ARB_IDLE) ? w_gnt : '0;
    assign busy      = (r_state != ARB_IDLE);

    // Response valid points only at the owner of the in-flight op while in RESP
    always_comb begin
        w_rsp_onehot        = '0;
        w_rsp_onehot[r_gnt] = 1'b1;
    end

    assign rsp_valid = (r_state == ARB_RESP) ? w_rsp_onehot : '0;

    // FSM and grant bookkeeping: ptr moves past the winner on every accept
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ARB_IDLE;
            r_ptr   <= '0;
            r_gnt   <= '0;
        end else begin
            case (r_state)
                ARB_IDLE: begin
                    if (w_accept) begin
                        r_gnt   <= w_gnt_idx;
                        r_ptr   <= (w_gnt_idx == IW'(NREQ-1)) ? '0 : w_gnt_idx + 1'b1;
                        r_state <= ARB_EXEC;
                    end
                end
                ARB_EXEC: r_state <= ARB_RESP;
                ARB_RESP: begin
                    if (rsp_ready[r_gnt]) begin
                        r_state <= ARB_IDLE;
                    end
                end
                default: r_state <= ARB_IDLE;
            endcase
        end
    end

    // Datapath: capture operands on accept, capture ALU result one cycle later
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_alu_a    <= '0;
            r_alu_b    <= '0;
            r_alu_ctrl <= '0;
            r_err      <= 1'b0;
            r_rsp_data <= '0;
            r_rsp_err  <= 1'b0;
        end else begin
            if (w_accept) begin
                r_alu_a <= req_a[w_gnt_idx];
                r_alu_b <= req_b[w_gnt_idx];
                // Illegal codes drive ADD into the ALU; the result is forced to zero later
                if (is_legal_op(w_op)) begin
                    r_alu_ctrl <= w_op;
                    r_err      <= 1'b0;
                end else begin
                    r_alu_ctrl <= 4'd0;
                    r_err      <= 1'b1;
                end
            end
            if (r_state == ARB_EXEC) begin
                r_rsp_data <= r_err ? '0 : alu_result;
                r_rsp_err  <= r_err;
            end
        end
    end

    assign alu_a    = r_alu_a;
    assign alu_b    = r_alu_b;
    assign alu_ctrl = r_alu_ctrl;
    assign rsp_data = r_rsp_data;
    assign rsp_err  = r_rsp_err;

endmodule

// File: tb/tb_alu_share_arbiter.sv
module tb_alu_share_arbiter;

    localparam int NREQ = 2;
    localparam int XLEN = 32;

    logic                      clk;
    logic                      rst_n;
    logic [NREQ-1:0]           req_valid;
    logic [NREQ-1:0]           req_ready;
    logic [NREQ-1:0][XLEN-1:0] req_a;
    logic [NREQ-1:0][XLEN-1:0] req_b;
    logic [NREQ-1:0][3:0]      req_op;
    logic [NREQ-1:0]           rsp_valid;
    logic [NREQ-1:0]           rsp_ready;
    logic [XLEN-1:0]           rsp_data;
    logic                      rsp_err;
    logic [XLEN-1:0]           alu_a;
    logic [XLEN-1:0]           alu_b;
    logic [3:0]                alu_ctrl;
    logic [XLEN-1:0]           alu_result;
    logic                      busy;

    int n_pass;
    int n_total;

    alu_share_arbiter #(.NREQ(NREQ), .XLEN(XLEN)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_a      (req_a),
        .req_b      (req_b),
        .req_op     (req_op),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_data   (rsp_data),
        .rsp_err    (rsp_err),
        .alu_a      (alu_a),
        .alu_b      (alu_b),
        .alu_ctrl   (alu_ctrl),
        .alu_result (alu_result),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // External RV32I ALU
    always_comb begin
        alu_result = '0;
        case (alu_ctrl)
            4'd0:  alu_result = alu_a + alu_b;
            4'd1:  alu_result = alu_a - alu_b;
            4'd2:  alu_result = alu_a << alu_b[4:0];
            4'd3:  alu_result = {31'd0, ($signed(alu_a) < $signed(alu_b))};
            4'd4:  alu_result = alu_a ^ alu_b;
            4'd5:  alu_result = {31'd0, (alu_a < alu_b)};
            4'd6:  alu_result = alu_a >> alu_b[4:0];
            4'd7:  alu_result = $unsigned($signed(alu_a) >>> alu_b[4:0]);
            4'd8:  alu_result = alu_a | alu_b;
            4'd9:  alu_result = alu_a & alu_b;
            4'd10: alu_result = alu_b;
            default: alu_result = '0;
        endcase
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, got timeout, required completion");
        $fatal(1, "watchdog");
    end

    task automatic apply_reset();
        @(negedge clk);
        rst_n     = 1'b0;
        req_valid = '0;
        rsp_ready = '0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Driver: issue one op from requester idx and collect its response (bounded waits)
    task automatic run_op(input int idx, input logic [31:0] a, input logic [31:0] b,
                          input logic [3:0] op, output logic [31:0] data,
                          output logic err, output bit ok);
        req_a[idx]     = a;
        req_b[idx]     = b;
        req_op[idx]    = op;
        req_valid[idx] = 1'b1;
        data = '0;
        err  = 1'b0;
        ok   = 1'b0;
        for (int c = 0; c < 20; c++) begin
            #1;
            if (req_ready[idx]) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        if (!ok) begin
            req_valid[idx] = 1'b0;
            return;
        end
        @(negedge clk);
        req_valid[idx] = 1'b0;
        ok = 1'b0;
        for (int c = 0; c < 20; c++) begin
            if (rsp_valid[idx]) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        if (!ok) return;
        data = rsp_data;
        err  = rsp_err;
        rsp_ready[idx] = 1'b1;
        @(negedge clk);
        rsp_ready[idx] = 1'b0;
    endtask

    task automatic test_reset();
        rst_n     = 1'b0;
        req_valid = '0;
        rsp_ready = '0;
        req_a     = '0;
        req_b     = '0;
        req_op    = '0;
        @(negedge clk);
        @(negedge clk);
        n_total++;
        if ({busy, rsp_valid, rsp_err, req_ready} !== 6'b0) begin
            $display("FAIL reset_ctrl: busy/rsp_valid/rsp_err/req_ready got %b, required 000000",
                     {busy, rsp_valid, rsp_err, req_ready});
        end else n_pass++;
        n_total++;
        if ({alu_a, alu_b, alu_ctrl, rsp_data} !== '0) begin
            $display("FAIL reset_data: alu_a=%h alu_b=%h alu_ctrl=%h rsp_data=%h, required all 0",
                     alu_a, alu_b, alu_ctrl, rsp_data);
        end else n_pass++;
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_add_latency();
        req_a[0] = 32'd5;
        req_b[0] = 32'd7;
        req_op[0] = 4'd0;
        req_valid[0] = 1'b1;
        #1;
        n_total++;
        if (req_ready !== 2'b01) $display("FAIL add_accept: req_ready got %b, required 01", req_ready);
        else n_pass++;
        @(negedge clk);
        req_valid[0] = 1'b0;
        n_total++;
        if (rsp_valid !== 2'b00 || busy !== 1'b1 || alu_a !== 32'd5 || alu_b !== 32'd7 || alu_ctrl !== 4'd0)
            $display("FAIL add_exec: rsp_valid=%b busy=%b alu_a=%0d alu_b=%0d ctrl=%0d, required 00 1 5 7 0",
                     rsp_valid, busy, alu_a, alu_b, alu_ctrl);
        else n_pass++;
        @(negedge clk);
        n_total++;
        if (rsp_valid !== 2'b01 || rsp_data !== 32'd12 || rsp_err !== 1'b0)
            $display("FAIL add_resp: rsp_valid=%b data=%0d err=%b, required 01 12 0",
                     rsp_valid, rsp_data, rsp_err);
        else n_pass++;
        rsp_ready[0] = 1'b1;
        @(negedge clk);
        rsp_ready[0] = 1'b0;
        n_total++;
        if (rsp_valid !== 2'b00 || busy !== 1'b0)
            $display("FAIL add_done: rsp_valid=%b busy=%b, required 00 0", rsp_valid, busy);
        else n_pass++;
    endtask

    task automatic test_ops();
        logic [31:0] d;
        logic        e;
        bit          ok;
        logic [31:0] a_tab [6] = '{32'd3, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h80000000, 32'd1, 32'h12345678};
        logic [31:0] b_tab [6] = '{32'd5, 32'd1, 32'd1, 32'd4, 32'd33, 32'hCAFEF00D};
        logic [3:0]  o_tab [6] = '{4'd1, 4'd3, 4'd5, 4'd7, 4'd2, 4'd10};
        logic [31:0] x_tab [6] = '{32'hFFFFFFFE, 32'd1, 32'd0, 32'hF8000000, 32'd2, 32'hCAFEF00D};
        for (int i = 0; i < 6; i++) begin
            run_op(1, a_tab[i], b_tab[i], o_tab[i], d, e, ok);
            n_total++;
            if (!ok || d !== x_tab[i] || e !== 1'b0)
                $display("FAIL op_%0d: ok=%0d data=%h err=%b, required ok=1 data=%h err=0",
                         o_tab[i], ok, d, e, x_tab[i]);
            else n_pass++;
        end
    endtask

    task automatic test_round_robin();
        logic [1:0]  exp_g;
        logic [31:0] exp_d;
        apply_reset();
        req_a[0] = 32'd100; req_b[0] = 32'd0; req_op[0] = 4'd0;
        req_a[1] = 32'd200; req_b[1] = 32'd0; req_op[1] = 4'd0;
        req_valid = 2'b11;
        rsp_ready = 2'b11;
        for (int g = 0; g < 4; g++) begin
            exp_g = (g % 2 == 0) ? 2'b01 : 2'b10;
            exp_d = (g % 2 == 0) ? 32'd100 : 32'd200;
            #1;
            n_total++;
            if (req_ready !== exp_g)
                $display("FAIL rr_grant_%0d: req_ready got %b, required %b", g, req_ready, exp_g);
            else n_pass++;
            @(negedge clk);
            @(negedge clk);
            n_total++;
            if (rsp_valid !== exp_g || rsp_data !== exp_d)
                $display("FAIL rr_resp_%0d: rsp_valid=%b data=%0d, required %b %0d",
                         g, rsp_valid, rsp_data, exp_g, exp_d);
            else n_pass++;
            @(negedge clk);
        end
        req_valid = '0;
        rsp_ready = '0;
    endtask

    task automatic test_illegal();
        logic [31:0] d;
        logic        e;
        bit          ok;
        run_op(0, 32'd9, 32'd9, 4'hC, d, e, ok);
        n_total++;
        if (!ok || e !== 1'b1 || d !== 32'd0)
            $display("FAIL illegal_op: ok=%0d err=%b data=%h, required ok=1 err=1 data=0", ok, e, d);
        else n_pass++;
        req_a[0] = 32'd1; req_b[0] = 32'd1; req_op[0] = 4'd0;
        req_a[1] = 32'd6; req_b[1] = 32'd3; req_op[1] = 4'd9;
        req_valid = 2'b11;
        #1;
        n_total++;
        if (req_ready !== 2'b10)
            $display("FAIL illegal_ptr: req_ready got %b, required 10", req_ready);
        else n_pass++;
        @(negedge clk);
        req_valid = 2'b00;
        @(negedge clk);
        n_total++;
        if (rsp_valid !== 2'b10 || rsp_data !== 32'd2 || rsp_err !== 1'b0)
            $display("FAIL illegal_after: rsp_valid=%b data=%0d err=%b, required 10 2 0",
                     rsp_valid, rsp_data, rsp_err);
        else n_pass++;
        rsp_ready[1] = 1'b1;
        @(negedge clk);
        rsp_ready[1] = 1'b0;
    endtask

    task automatic test_stall();
        req_a[0] = 32'd10; req_b[0] = 32'd20; req_op[0] = 4'd0;
        req_valid[0] = 1'b1;
        #1;
        n_total++;
        if (req_ready !== 2'b01) $display("FAIL stall_accept: req_ready got %b, required 01", req_ready);
        else n_pass++;
        @(negedge clk);
        req_valid[0] = 1'b0;
        req_a[1] = 32'd1; req_b[1] = 32'd1; req_op[1] = 4'd0;
        req_valid[1] = 1'b1;
        @(negedge clk);
        rsp_ready[1] = 1'b1;
        for (int i = 0; i < 5; i++) begin
            n_total++;
            if (rsp_valid !== 2'b01 || rsp_data !== 32'd30 || req_ready !== 2'b00)
                $display("FAIL stall_hold_%0d: rsp_valid=%b data=%0d req_ready=%b, required 01 30 00",
                         i, rsp_valid, rsp_data, req_ready);
            else n_pass++;
            @(negedge clk);
        end
        rsp_ready = 2'b01;
        @(negedge clk);
        rsp_ready = 2'b00;
        #1;
        n_total++;
        if (req_ready !== 2'b10) $display("FAIL stall_next: req_ready got %b, required 10", req_ready);
        else n_pass++;
        @(negedge clk);
        req_valid[1] = 1'b0;
        @(negedge clk);
        n_total++;
        if (rsp_valid !== 2'b10 || rsp_data !== 32'd2)
            $display("FAIL stall_resp1: rsp_valid=%b data=%0d, required 10 2", rsp_valid, rsp_data);
        else n_pass++;
        rsp_ready[1] = 1'b1;
        @(negedge clk);
        rsp_ready[1] = 1'b0;
    endtask

    task automatic test_reset_in_exec();
        bit seen;
        req_a[0] = 32'd40; req_b[0] = 32'd2; req_op[0] = 4'd0;
        req_valid[0] = 1'b1;
        @(negedge clk);
        req_valid[0] = 1'b0;
        n_total++;
        if (busy !== 1'b1) $display("FAIL rst_exec_busy: busy got %b, required 1", busy);
        else n_pass++;
        rst_n = 1'b0;
        #1;
        n_total++;
        if (busy !== 1'b0 || rsp_valid !== 2'b00 || alu_a !== 32'd0)
            $display("FAIL rst_exec_async: busy=%b rsp_valid=%b alu_a=%0d, required 0 00 0",
                     busy, rsp_valid, alu_a);
        else n_pass++;
        @(negedge clk);
        rst_n = 1'b1;
        rsp_ready = 2'b11;
        seen = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (rsp_valid !== 2'b00) seen = 1'b1;
            @(negedge clk);
        end
        rsp_ready = 2'b00;
        n_total++;
        if (seen) $display("FAIL rst_exec_norsp: rsp_valid seen 1, required 0");
        else n_pass++;
        req_a[0] = 32'd7; req_b[0] = 32'd8; req_op[0] = 4'd8;
        req_a[1] = 32'd1; req_b[1] = 32'd1; req_op[1] = 4'd0;
        req_valid = 2'b11;
        #1;
        n_total++;
        if (req_ready !== 2'b01) $display("FAIL rst_exec_ptr: req_ready got %b, required 01", req_ready);
        else n_pass++;
        @(negedge clk);
        req_valid = 2'b00;
        @(negedge clk);
        n_total++;
        if (rsp_valid !== 2'b01 || rsp_data !== 32'd15 || rsp_err !== 1'b0)
            $display("FAIL rst_exec_serve: rsp_valid=%b data=%0d err=%b, required 01 15 0",
                     rsp_valid, rsp_data, rsp_err);
        else n_pass++;
        rsp_ready[0] = 1'b1;
        @(negedge clk);
        rsp_ready[0] = 1'b0;
    endtask

    initial begin
        n_pass  = 0;
        n_total = 0;
        test_reset();
        test_add_latency();
        test_ops();
        test_round_robin();
        test_illegal();
        test_stall();
        test_reset_in_exec();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
